// File: rtl/sorted_stream_unloader.sv
// Serialises one wide sorted block per y_valid into a valid/ready element stream,
// with an active slot being drained and one pending slot to absorb back-to-back results.
module sorted_stream_unloader #(
    parameter int LOG_INPUT  = 8,
    parameter int DATA_WIDTH = 32,
    parameter bit REVERSE    = 1'b0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  y_valid,
    input  logic [DATA_WIDTH*(1<<LOG_INPUT)-1:0]  y,
    output logic                                  in_ready,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [DATA_WIDTH-1:0]                 m_data,
    output logic [LOG_INPUT-1:0]                  m_index,
    output logic                                  m_last,
    output logic                                  overflow
);
    localparam int N = 1 << LOG_INPUT;
    localparam logic [LOG_INPUT-1:0] LAST_COUNT = '1;

    typedef logic [N-1:0][DATA_WIDTH-1:0] block_t;

    block_t                 y_blk;
    block_t                 active_buf;
    block_t                 pending_buf;
    logic                   active_valid;
    logic                   pending_valid;
    logic [LOG_INPUT-1:0]   count;
    logic                   hs;
    logic                   last_hs;

    // Packed layout puts element i at y[DATA_WIDTH*i +: DATA_WIDTH].
    assign y_blk   = y;

    assign hs      = active_valid & m_ready;
    assign last_hs = hs & (count == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            active_valid  <= 1'b0;
            pending_valid <= 1'b0;
            count         <= '0;
            active_buf    <= '0;
            pending_buf   <= '0;
            overflow      <= 1'b0;
        end else if (y_valid) begin
            if (!active_valid) begin
                active_buf   <= y_blk;
                active_valid <= 1'b1;
                count        <= '0;
            end else if (last_hs && !pending_valid) begin
                // Gapless: the next block starts on the cycle after the last element.
                active_buf   <= y_blk;
                count        <= '0;
            end else if (last_hs) begin
                active_buf   <= pending_buf;
                pending_buf  <= y_blk;
                count        <= '0;
            end else begin
                if (!pending_valid) begin
                    pending_buf   <= y_blk;
                    pending_valid <= 1'b1;
                end else begin
                    overflow      <= 1'b1;
                end
                if (hs) count <= count + 1'b1;
            end
        end else if (last_hs) begin
            if (pending_valid) begin
                active_buf    <= pending_buf;
                pending_valid <= 1'b0;
            end else begin
                active_valid  <= 1'b0;
            end
            count <= '0;
        end else if (hs) begin
            count <= count + 1'b1;
        end
    end

    assign m_valid  = active_valid;
    assign m_index  = REVERSE ? ~count : count;
    assign m_data   = active_buf[m_index];
    assign m_last   = (count == LAST_COUNT) & active_valid;
    assign in_ready = !pending_valid;

endmodule

// File: tb/tb_sorted_stream_unloader.sv
// Directed bench: forward and reversed instances share stimulus; a negedge monitor
// pops expected elements from per-instance queues on every handshake.
module tb_sorted_stream_unloader;
    localparam int LI = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          y_valid = 1'b0;
    logic [31:0]   y = '0;
    logic          m_ready = 1'b0;

    logic          in_ready, m_valid, m_last, overflow;
    logic [DW-1:0] m_data;
    logic [LI-1:0] m_index;
    logic          r_in_ready, r_m_valid, r_m_last, r_overflow;
    logic [DW-1:0] r_m_data;
    logic [LI-1:0] r_m_index;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    sorted_stream_unloader #(.LOG_INPUT(LI), .DATA_WIDTH(DW), .REVERSE(1'b0)) dut (
        .clk(clk), .rst(rst), .y_valid(y_valid), .y(y), .in_ready(in_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
        .m_last(m_last), .overflow(overflow)
    );

    sorted_stream_unloader #(.LOG_INPUT(LI), .DATA_WIDTH(DW), .REVERSE(1'b1)) dut_r (
        .clk(clk), .rst(rst), .y_valid(y_valid), .y(y), .in_ready(r_in_ready),
        .m_valid(r_m_valid), .m_ready(m_ready), .m_data(r_m_data), .m_index(r_m_index),
        .m_last(r_m_last), .overflow(r_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_block(input logic [31:0] blk);
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{blk[8*i +: 8], 2'(i), i == 3});
            q1.push_back('{blk[8*(3-i) +: 8], 2'(3-i), i == 3});
        end
    endtask

    // Step to just after the next rising edge; inputs set here are sampled next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int guard;
        m_ready = 1'b1;
        guard = 0;
        while (m_valid && guard < 40) begin
            tick();
            guard++;
        end
        check({name, "_drain_done"}, m_valid, 1'b0);
        check({name, "_q_empty"}, q0.size() + q1.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (m_valid && m_ready) begin
                if (q0.size() == 0) begin
                    check("fwd_unexpected_elem", m_data, 0);
                end else begin
                    e = q0.pop_front();
                    check("fwd_data", m_data, e.data);
                    check("fwd_index", m_index, e.idx);
                    check("fwd_last", m_last, e.last);
                end
            end
            if (r_m_valid && m_ready) begin
                if (q1.size() == 0) begin
                    check("rev_unexpected_elem", r_m_data, 0);
                end else begin
                    e = q1.pop_front();
                    check("rev_data", r_m_data, e.data);
                    check("rev_index", r_m_index, e.idx);
                    check("rev_last", r_m_last, e.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;
        logic [6:0] pat;

        // Reset with y_valid held high: nothing may be captured.
        rst = 1'b1; y_valid = 1'b1; y = 32'hdeadbeef; m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_m_valid", m_valid, 1'b0);
            check("rst_in_ready", in_ready, 1'b1);
            check("rst_overflow", overflow, 1'b0);
            check("rst_m_data", m_data, 8'h00);
        end
        rst = 1'b0; y_valid = 1'b0;
        tick();
        check("post_rst_m_valid", m_valid, 1'b0);
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_m_data", m_data, 8'h00);
        check("post_rst_m_index", m_index, 2'd0);
        check("post_rst_m_last", m_last, 1'b0);

        // Single block, one-cycle latency, N cycles of output.
        y = 32'h40302010; y_valid = 1'b1; push_block(y);
        tick();
        y_valid = 1'b0;
        check("single_first_valid", m_valid, 1'b1);
        check("single_first_data", m_data, 8'h10);
        check("single_first_rev", r_m_data, 8'h40);
        check("single_first_rev_idx", r_m_index, 2'd3);
        check("single_first_last", m_last, 1'b0);
        tick(); tick(); tick();
        check("single_t4_data", m_data, 8'h40);
        check("single_t4_last", m_last, 1'b1);
        tick();
        check("single_t5_valid", m_valid, 1'b0);
        check("single_q_empty", q0.size() + q1.size(), 0);

        // Backpressure pattern 1,0,0,1,0,1,1 applied to successive cycles.
        m_ready = 1'b0;
        y = 32'h40302010; y_valid = 1'b1; push_block(y);
        tick();
        y_valid = 1'b0;
        pat = 7'b1101001;
        for (int k = 0; k < 7; k++) begin
            m_ready = pat[k];
            held = m_data;
            tick();
            if (k == 1) check("bp_hold_data", m_data, held);
        end
        check("bp_done_valid", m_valid, 1'b0);
        check("bp_q_empty", q0.size() + q1.size(), 0);

        // Back-to-back blocks: B follows A with no bubble.
        m_ready = 1'b1;
        y = 32'h04030201; y_valid = 1'b1; push_block(y);
        tick();
        y = 32'h08070605; push_block(y);
        tick();
        y_valid = 1'b0;
        check("b2b_in_ready_low", in_ready, 1'b0);
        tick(); tick(); tick();
        check("b2b_b0_valid", m_valid, 1'b1);
        check("b2b_b0_data", m_data, 8'h05);
        check("b2b_in_ready_high", in_ready, 1'b1);
        drain("b2b");

        // Overflow: third block dropped while stalled.
        m_ready = 1'b0;
        y = 32'hc3c2c1c0; y_valid = 1'b1; push_block(y);
        tick();
        y = 32'hd3d2d1d0; push_block(y);
        tick();
        check("ovf_before", overflow, 1'b0);
        y = 32'he3e2e1e0;
        tick();
        y_valid = 1'b0;
        check("ovf_set", overflow, 1'b1);
        tick();
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_in_ready", in_ready, 1'b0);
        // Capture on the same cycle as the last handshake with PENDING full.
        m_ready = 1'b1;
        tick(); tick(); tick();
        check("sim_last_shown", m_last, 1'b1);
        check("sim_c3", m_data, 8'hc3);
        y = 32'hf3f2f1f0; y_valid = 1'b1; push_block(y);
        tick();
        y_valid = 1'b0;
        check("sim_d0", m_data, 8'hd0);
        check("sim_in_ready", in_ready, 1'b0);
        check("sim_ovf_unchanged", overflow, 1'b1);
        drain("sim");
        check("sim_ovf_after", overflow, 1'b1);

        // Reset mid-stream with PENDING full.
        m_ready = 1'b0;
        y = 32'h33221100; y_valid = 1'b1; push_block(y);
        tick();
        y = 32'h77665544; push_block(y);
        tick();
        y_valid = 1'b0;
        m_ready = 1'b1;
        tick(); tick();
        check("mid_elem2", m_data, 8'h22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q0.delete(); q1.delete();
        check("mid_rst_valid", m_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_overflow", overflow, 1'b0);
        tick();
        check("mid_rst_idle", m_valid, 1'b0);
        y = 32'hbbaa9988; y_valid = 1'b1; push_block(y);
        tick();
        y_valid = 1'b0;
        check("fresh_data", m_data, 8'h88);
        check("fresh_index", m_index, 2'd0);
        drain("fresh");

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sorted_stream_unloader.md
Name: sorted_stream_unloader

Overview:
- Drains the wide, fully parallel result of the odd-even merge sorter (y / y_valid) into a one-element-per-cycle stream with valid/ready backpressure.
- Holds up to two complete sorted blocks (active + pending) so back-to-back sorter results are not lost while the consumer stalls.
- Sits directly after the sorter top; it is the receiving end of the sorter's wide result interface.

Parameters:
- LOG_INPUT, 8, log2 of elements per block; N = 2**LOG_INPUT; legal range >= 1.
- DATA_WIDTH, 32, bits per element.
- REVERSE, 0, emission order. 0 = element 0 first; 1 = element N-1 first.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- y_valid  input  1  one-cycle qualifier; a complete sorted block is on y this cycle.
- y  input  DATA_WIDTH*N  sorted block; element i = y[DATA_WIDTH*i +: DATA_WIDTH].
- in_ready  output  1  high when the pending slot is empty (advisory; the sorter has no stall).
- m_valid  output  1  stream element valid.
- m_ready  input  1  consumer accepts the element.
- m_data  output  DATA_WIDTH  current element.
- m_index  output  LOG_INPUT  block index of the current element.
- m_last  output  1  current element is the final one of its block.
- overflow  output  1  sticky; a block was dropped.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: active_valid=0, pending_valid=0, count=0, both buffers=0, overflow=0. Therefore m_valid=0, m_data=0, m_index=0, m_last=0, in_ready=1. Reset wins over every simultaneous event and aborts any stream in progress: m_valid=0 on the next cycle and buffered data is discarded.
- State: two slots, ACTIVE and PENDING, each a flag plus an N-element register. pending_valid=1 implies active_valid=1.
- Handshake: hs = m_valid & m_ready; last_hs = hs & m_last.
- Capture on y_valid, in priority order:
  - (a) active empty -> load ACTIVE, count=0.
  - (b) last_hs and PENDING empty -> load ACTIVE directly, count=0 (gapless).
  - (c) last_hs and PENDING full -> PENDING moves to ACTIVE, new block goes to PENDING; no drop.
  - (d) PENDING empty -> load PENDING.
  - (e) otherwise drop the block and set overflow=1 (registered, next cycle). overflow clears only on rst.
- Without y_valid, last_hs moves PENDING to ACTIVE if pending_valid=1, else clears active_valid; count returns to 0.
- Output mapping:
  - m_valid = active_valid.
  - m_index = count when REVERSE=0, else N-1-count.
  - m_data = ACTIVE element[m_index].
  - m_last = (count == N-1) & m_valid.
  - Outputs are driven from registers plus a mux; no combinational path from m_ready to m_valid.
- Counter: on hs and not last, count increments by 1. It never wraps within a block; it resets to 0 on block switch.
- Stall: while m_valid & !m_ready, m_data, m_index and m_last are held stable.
- Latency: y_valid at cycle t into an empty unit gives the first element (m_valid=1) at t+1. An uninterrupted block occupies N cycles.
- in_ready = !pending_valid (registered state).
- LOG_INPUT=1: N=2, count is 1 bit, m_last on the second element.

Test Plan:
- Reset (LOG_INPUT=2, DATA_WIDTH=8): assert rst 3 cycles with y_valid=1 -> m_valid=0, in_ready=1, overflow=0, m_data=0 throughout and on the first cycle after release.
- Single block: y={8'h40,8'h30,8'h20,8'h10}, y_valid pulse at t, m_ready=1 -> m_data 10,20,30,40 at t+1..t+4. m_index 0..3; m_last only at t+4; m_valid=0 at t+5. With REVERSE=1 -> 40,30,20,10 and m_index 3..0.
- Backpressure: same block, m_ready pattern 1,0,0,1,0,1,1 -> each element held while m_ready=0, exactly 4 handshakes, no repeat or skip.
- Back-to-back: blocks A at t and B at t+1, m_ready=1 -> in_ready=0 from t+2. B element 0 appears at t+5 with no bubble; in_ready=1 at t+5.
- Overflow and simultaneous capture: m_ready=0, blocks at t, t+1, t+2 -> third block dropped, overflow=1 at t+3 and stays high. Then, with PENDING full, issue y_valid on the same cycle as last_hs -> new block retained, overflow unchanged.
- Reset mid-stream: assert rst during element 2 of a block with PENDING full -> next cycle m_valid=0, in_ready=1, overflow=0. A fresh block then streams from element 0.
